// File: rtl/sa_skew_feeder.sv
// Input-side feeder for a systolic array: accepts N-word row beats and skews
// lane k by k extra cycles, framing the job with preload/busy/done.
module sa_skew_feeder #(
  parameter int unsigned WORD_LEN = 4,
  parameter int unsigned N        = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [N*WORD_LEN-1:0] in_data,
  output logic [N*WORD_LEN-1:0] out_data,
  output logic [N-1:0]          out_tag,
  output logic                  preload,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      beat_cnt
);

  localparam int unsigned DW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q;
  logic [DW-1:0]    drain_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic             preload_q;
  logic             busy_q;
  logic             done_q;
  logic             accept;

  assign in_ready = (state_q == FEED);
  assign accept   = in_valid & in_ready;

  // Job control; preload/busy/done are registered alongside the state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      drain_q    <= '0;
      beat_cnt_q <= '0;
      preload_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= FEED;
            beat_cnt_q <= '0;
            preload_q  <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        FEED: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            if (in_last) begin
              state_q <= DRAIN;
              drain_q <= '0;
            end
          end
        end
        DRAIN: begin
          if (drain_q == DW'(N - 1)) begin
            state_q   <= DONE;
            preload_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Lane k: free-running chain of k+1 registers, zero/tag-0 bubbles when idle.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [WORD_LEN-1:0] data_q [0:k];
    logic [k:0]          tag_q;

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        for (int j = 0; j <= k; j++) begin
          data_q[j] <= '0;
        end
        tag_q <= '0;
      end else begin
        data_q[0] <= accept ? in_data[k*WORD_LEN +: WORD_LEN] : '0;
        tag_q[0]  <= accept;
        for (int j = 1; j <= k; j++) begin
          data_q[j] <= data_q[j-1];
          tag_q[j]  <= tag_q[j-1];
        end
      end
    end

    assign out_data[k*WORD_LEN +: WORD_LEN] = data_q[k];
    assign out_tag[k]                       = tag_q[k];
  end

  assign preload  = preload_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Scoreboard bench for sa_skew_feeder: the driver pushes expected per-lane
// words and done cycles; a negedge monitor pops and compares every cycle.
module tb_sa_skew_feeder;

  localparam int unsigned W  = 4;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = 2;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_last = 1'b0;
  logic [N*W-1:0]  in_data = '0;
  logic [N*W-1:0]  out_data;
  logic [N-1:0]    out_tag;
  logic            preload;
  logic            busy;
  logic            done;
  logic [CW-1:0]   beat_cnt;

  sa_skew_feeder #(.WORD_LEN(W), .N(N), .CNT_W(CW)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .in_data  (in_data),
    .out_data (out_data),
    .out_tag  (out_tag),
    .preload  (preload),
    .busy     (busy),
    .done     (done),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           lane;
    logic [W-1:0] d;
    int           c;
  } exp_t;

  exp_t sb[$];
  int   done_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   pl_cnt = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every lane every cycle must match the scoreboard exactly.
  always @(negedge clk) begin
    logic [W-1:0] ev;
    bit           found;
    bit           exp_done;
    if (mon_en) begin
      for (int k = 0; k < N; k++) begin
        found = 1'b0;
        ev    = '0;
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].lane == k && sb[i].c == cyc) begin
            ev    = sb[i].d;
            found = 1'b1;
            sb.delete(i);
            break;
          end
        end
        chk($sformatf("lane%0d_tag", k), 64'(out_tag[k]), 64'(found));
        chk($sformatf("lane%0d_data", k), 64'(out_data[k*W +: W]), 64'(ev));
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].c < cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL lane%0d_missing: got nothing required %0h at cycle %0d",
                   sb[i].lane, sb[i].d, sb[i].c);
          sb.delete(i);
        end
      end
      exp_done = (done_q.size() > 0 && done_q[0] == cyc);
      if (exp_done) void'(done_q.pop_front());
      chk("done", 64'(done), 64'(exp_done));
      if (preload) pl_cnt++;
    end
  end

  task automatic start_job();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [N*W-1:0] d, input bit last);
    int e;
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_beat_timeout: in_ready got 0 required 1 (cycle %0d)", cyc);
    end else begin
      chk("busy_in_feed", 64'(busy), 64'd1);
      chk("preload_in_feed", 64'(preload), 64'd1);
      e = cyc + 1;
      for (int k = 0; k < N; k++) sb.push_back('{k, d[k*W +: W], e + k});
      if (last) done_q.push_back(e + N);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_done(input logic [CW-1:0] exp_cnt, input string name);
    int g;
    g = 0;
    while (!done && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_done_timeout: done got 0 required 1 (cycle %0d)", name, cyc);
    end else begin
      chk({name, "_beat_cnt"}, 64'(beat_cnt), 64'(exp_cnt));
      chk({name, "_busy_done"}, 64'(busy), 64'd0);
      chk({name, "_preload_done"}, 64'(preload), 64'd0);
    end
    @(negedge clk);
    chk({name, "_busy_idle"}, 64'(busy), 64'd0);
    chk({name, "_ready_idle"}, 64'(in_ready), 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_out_data"}, 64'(out_data), 64'd0);
    chk({name, "_out_tag"}, 64'(out_tag), 64'd0);
    chk({name, "_preload"}, 64'(preload), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({name, "_beat_cnt"}, 64'(beat_cnt), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    #12;
    check_all_zero("reset");
    @(negedge clk);
    nrst   = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Back-to-back three-beat job.
    start_job();
    send_beat(16'h4321, 1'b0);
    send_beat(16'h8765, 1'b0);
    send_beat(16'hCBA9, 1'b1);
    wait_done(2'd3, "t1");

    // Same job with a two-cycle bubble after the first beat.
    start_job();
    send_beat(16'h4321, 1'b0);
    repeat (2) @(negedge clk);
    send_beat(16'h8765, 1'b0);
    send_beat(16'hCBA9, 1'b1);
    wait_done(2'd3, "t2");

    // start with in_valid in IDLE, then stray starts while busy.
    in_valid = 1'b1;
    in_data  = 16'h1357;
    start    = 1'b1;
    chk("t3_ready_at_start", 64'(in_ready), 64'd0);
    @(negedge clk);
    start = 1'b0;
    send_beat(16'h1357, 1'b0);
    start = 1'b1;
    send_beat(16'h2468, 1'b0);
    start = 1'b0;
    send_beat(16'h9ACE, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2'd3, "t3");

    // Single full-scale beat: one word per lane, preload high 5 cycles.
    pl_cnt = 0;
    start_job();
    send_beat(16'hFFFF, 1'b1);
    wait_done(2'd1, "t5");
    chk("t5_preload_cycles", 64'(pl_cnt), 64'd5);

    // Asynchronous reset during DRAIN aborts the job.
    start_job();
    send_beat(16'h1111, 1'b0);
    send_beat(16'h2222, 1'b1);
    repeat (2) @(negedge clk);
    #2;
    mon_en = 1'b0;
    nrst   = 1'b0;
    #1;
    check_all_zero("t4_async");
    sb.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    chk("t4_busy_after", 64'(busy), 64'd0);
    chk("t4_ready_after", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clk);
    start_job();
    send_beat(16'h5A5A, 1'b1);
    wait_done(2'd1, "t4");

    // Five beats wrap the 2-bit beat counter to 1.
    start_job();
    for (int i = 1; i <= 5; i++) send_beat(16'(16'h1111 * i), i == 5);
    wait_done(2'd1, "t6");

    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
